sig_gen: RTL and testbench
==========================

SIG_GEN -- requirements
Module: sig_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of period, high-time, pulse and elapsed counters.
REQ-002 SHALL have port clk_i, input, 1, the single system clock; all logic in this clock domain.
REQ-003 SHALL have port rst_n_i, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have port cfg_wr_en_i, input, 1, config write strobe; latches the three cfg_* inputs when IDLE.
REQ-005 SHALL have port cfg_period_i, input, CNT_W, signal period in clk_i cycles.
REQ-006 SHALL have port cfg_high_i, input, CNT_W, high-phase length in clk_i cycles.
REQ-007 SHALL have port cfg_pulses_i, input, CNT_W, number of periods to emit; 0 = continuous.
REQ-008 SHALL have port start_i, input, 1, single-cycle start request.
REQ-009 SHALL have port stop_i, input, 1, single-cycle graceful-stop request.
REQ-010 SHALL have port sig_clk_o, output, 1, registered generated square wave.
REQ-011 SHALL have port busy_o, output, 1, high while generating.
REQ-012 SHALL have port err_o, output, 1, one-cycle pulse on a rejected start.
REQ-013 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port done_data_o, output, 2*CNT_W, {elapsed clk cycles, pulses emitted}, held between done pulses.

Function
REQ-015 SHALL implement states IDLE, HIGH, LOW.
REQ-016 SHALL treat a config as valid only when cfg_period >= 2 and 1 <= cfg_high <= cfg_period-1.
REQ-017 SHALL ignore cfg_wr_en_i while busy_o=1.
REQ-018 SHALL, on start_i in IDLE with valid latched config at edge N, enter HIGH with sig_clk_o=1 and busy_o=1 after edge N.
REQ-019 SHALL, on start_i in IDLE with invalid config, stay IDLE and pulse err_o for the next cycle.
REQ-020 SHALL hold sig_clk_o=1 for exactly cfg_high cycles, then 0 for exactly cfg_period-cfg_high cycles, per period.
REQ-021 SHALL increment the pulse counter at the end of each complete period.
REQ-022 SHALL increment the elapsed counter on every busy cycle; both counters wrap modulo 2^CNT_W.
REQ-023 SHALL, at the end of the period where pulse count reaches a non-zero cfg_pulses, return to IDLE with sig_clk_o=0, busy_o=0, and pulse done_o with done_data_o updated in the same cycle.
REQ-024 SHALL, on stop_i while busy, finish the current period and then complete as in REQ-023.
REQ-025 SHALL ignore stop_i in IDLE; start_i and stop_i together in IDLE SHALL start generation and discard the stop.
REQ-026 SHALL ignore start_i while busy.
REQ-027 SHALL clear both counters on every accepted start.
REQ-028 SHALL ensure done_o and err_o are never high together.

Reset
REQ-029 SHALL, while rst_n_i=0 at a clk_i edge, force IDLE with sig_clk_o=0, busy_o=0, done_o=0, err_o=0, done_data_o=0, counters=0, latched config=0.
REQ-030 SHALL, on reset mid-operation, abort without a done_o pulse.

Configuration
REQ-031 SHALL, with macro SIG_GEN_ELAPSED_EN defined, implement the elapsed counter and drive the upper CNT_W bits of done_data_o from it.
REQ-032 SHALL, with SIG_GEN_ELAPSED_EN undefined, omit the elapsed counter and drive the upper CNT_W bits of done_data_o to 0.

Structure
REQ-033 SHALL take the state enum, the CNT_W default and the minimum period constant (2) from shared package sig_gen_pkg.
REQ-034 SHALL be implemented as a single module with no sub-module; phase and pulse counters are inline.

Verification
REQ-035 SHALL cover: period=4, high=2, pulses=3, start -> sig_clk_o pattern 1100 x3, done_o after 12 busy cycles, done_data_o={12,3}.
REQ-036 SHALL cover: pulses=0, period=5, high=1, stop_i in the 3rd cycle of period 7 -> period 7 completes, done_data_o={35,7}.
REQ-037 SHALL cover: period=1, or high=0, or high=period, then start -> err_o pulses once, busy_o stays 0, sig_clk_o stays 0.
REQ-038 SHALL cover: rst_n_i=0 for one cycle mid-HIGH -> all outputs 0 next cycle, no done_o, and a new start works normally.
REQ-039 SHALL cover: with SIG_GEN_ELAPSED_EN undefined, re-run the first scenario -> done_data_o={0,3}.
REQ-040 SHALL cover: start_i and cfg_wr_en_i with new values while busy -> both ignored, and the original waveform and count are unchanged.

Source files
------------

// File: rtl/sig_gen_pkg.sv
// Shared definitions for the sig_gen square-wave generator: FSM state
// encoding, default counter width and the shortest legal period.
package sig_gen_pkg;

    // Default width of the period, high-time, pulse and elapsed counters
    localparam int SIG_GEN_CNT_W = 32;

    // A period needs at least one high and one low cycle
    localparam int SIG_GEN_MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage : sig_gen_pkg

// File: rtl/sig_gen.sv
// sig_gen: programmable square-wave generator.
// Emits cfg_pulses periods (0 = run until stop) of a wave that is high for
// cfg_high cycles and low for the rest of cfg_period. On completion a one-cycle
// done_o pulse is issued together with {elapsed cycles, pulses emitted}.
// Build option: define SIG_GEN_ELAPSED_EN to include the elapsed-cycle counter;
// without it the upper half of done_data_o reads as zero.
module sig_gen
    import sig_gen_pkg::*;
#(
    parameter int CNT_W = SIG_GEN_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cfg_wr_en_i,
    input  logic [CNT_W-1:0]     cfg_period_i,
    input  logic [CNT_W-1:0]     cfg_high_i,
    input  logic [CNT_W-1:0]     cfg_pulses_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic                 sig_clk_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 done_o,
    output logic [2*CNT_W-1:0]   done_data_o
);

    state_t               state_reg;
    logic [CNT_W-1:0]     period_reg;
    logic [CNT_W-1:0]     high_reg;
    logic [CNT_W-1:0]     pulses_reg;
    logic [CNT_W-1:0]     phase_reg;
    logic [CNT_W-1:0]     pulse_cnt_reg;
    logic                 stop_pend_reg;
    logic                 sig_reg;
    logic                 done_reg;
    logic                 err_reg;
    logic [2*CNT_W-1:0]   done_data_reg;

    logic                 busy;
    logic                 cfg_valid;
    logic                 period_end;
    logic                 finish;
    logic [CNT_W-1:0]     phase_next;
    logic [CNT_W-1:0]     pulse_cnt_next;
    logic [CNT_W-1:0]     elapsed_field;

    assign busy = (state_reg != ST_IDLE);

    // Period must leave room for at least one high and one low cycle
    assign cfg_valid = (period_reg >= CNT_W'(SIG_GEN_MIN_PERIOD))
                    && (high_reg != '0)
                    && (high_reg < period_reg);

    assign phase_next     = phase_reg + CNT_W'(1);
    assign pulse_cnt_next = pulse_cnt_reg + CNT_W'(1);
    assign period_end     = busy && (phase_reg == period_reg - CNT_W'(1));

    // A stop arriving in the last cycle of a period ends that same period
    assign finish = period_end
                 && (((pulses_reg != '0) && (pulse_cnt_next == pulses_reg))
                     || stop_pend_reg || stop_i);

`ifdef SIG_GEN_ELAPSED_EN
    logic [CNT_W-1:0] elapsed_reg;
    logic [CNT_W-1:0] elapsed_next;

    assign elapsed_next  = elapsed_reg + CNT_W'(1);
    // done_data must include the final busy cycle, hence the incremented value
    assign elapsed_field = elapsed_next;

    // Elapsed counter: cleared on accepted start, counts every busy cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            elapsed_reg <= '0;
        end else if (!busy) begin
            if (start_i && cfg_valid) begin
                elapsed_reg <= '0;
            end
        end else begin
            elapsed_reg <= elapsed_next;
        end
    end
`else
    assign elapsed_field = '0;
`endif

    // Main FSM: config latch, phase/pulse counting, stop handling, completion
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            period_reg    <= '0;
            high_reg      <= '0;
            pulses_reg    <= '0;
            phase_reg     <= '0;
            pulse_cnt_reg <= '0;
            stop_pend_reg <= 1'b0;
            sig_reg       <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            done_data_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_wr_en_i) begin
                        period_reg <= cfg_period_i;
                        high_reg   <= cfg_high_i;
                        pulses_reg <= cfg_pulses_i;
                    end
                    // stop_i is dropped here, including when paired with start_i
                    if (start_i) begin
                        if (cfg_valid) begin
                            state_reg     <= ST_HIGH;
                            sig_reg       <= 1'b1;
                            phase_reg     <= '0;
                            pulse_cnt_reg <= '0;
                            stop_pend_reg <= 1'b0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (stop_i) begin
                        stop_pend_reg <= 1'b1;
                    end
                    if (period_end) begin
                        pulse_cnt_reg <= pulse_cnt_next;
                        if (finish) begin
                            state_reg     <= ST_IDLE;
                            sig_reg       <= 1'b0;
                            done_reg      <= 1'b1;
                            stop_pend_reg <= 1'b0;
                            done_data_reg <= {elapsed_field, pulse_cnt_next};
                        end else begin
                            state_reg <= ST_HIGH;
                            sig_reg   <= 1'b1;
                            phase_reg <= '0;
                        end
                    end else begin
                        phase_reg <= phase_next;
                        if (phase_next == high_reg) begin
                            state_reg <= ST_LOW;
                            sig_reg   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    sig_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign sig_clk_o   = sig_reg;
    assign busy_o      = busy;
    assign err_o       = err_reg;
    assign done_o      = done_reg;
    assign done_data_o = done_data_reg;

endmodule : sig_gen

// File: tb/tb_sig_gen.sv
// Directed testbench for sig_gen with hand-computed expected waveforms and
// completion data. Works with or without SIG_GEN_ELAPSED_EN defined.
module tb_sig_gen;

    localparam int CNT_W = 32;

`ifdef SIG_GEN_ELAPSED_EN
    localparam bit EL_EN = 1'b1;
`else
    localparam bit EL_EN = 1'b0;
`endif

    logic               clk_i;
    logic               rst_n_i;
    logic               cfg_wr_en_i;
    logic [CNT_W-1:0]   cfg_period_i;
    logic [CNT_W-1:0]   cfg_high_i;
    logic [CNT_W-1:0]   cfg_pulses_i;
    logic               start_i;
    logic               stop_i;
    logic               sig_clk_o;
    logic               busy_o;
    logic               err_o;
    logic               done_o;
    logic [2*CNT_W-1:0] done_data_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    sig_gen #(.CNT_W(CNT_W)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .cfg_wr_en_i  (cfg_wr_en_i),
        .cfg_period_i (cfg_period_i),
        .cfg_high_i   (cfg_high_i),
        .cfg_pulses_i (cfg_pulses_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .sig_clk_o    (sig_clk_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .done_o       (done_o),
        .done_data_o  (done_data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [63:0] exp_dd(input int cycles, input int pulses);
        logic [31:0] el;
        el = EL_EN ? 32'(cycles) : 32'd0;
        return {el, 32'(pulses)};
    endfunction

    task automatic write_cfg(input int period, input int high, input int pulses);
        cfg_wr_en_i  = 1'b1;
        cfg_period_i = 32'(period);
        cfg_high_i   = 32'(high);
        cfg_pulses_i = 32'(pulses);
        tick();
        cfg_wr_en_i  = 1'b0;
    endtask

    // Start, record n cycles of sig_clk_o, then check the completion cycle
    task automatic run_and_check(input string tag, input int n, input logic [63:0] exp_pat,
                                 input logic [63:0] exp_data, input bit inject,
                                 input bit stop_with_start);
        logic [63:0] pat;
        pat = '0;
        start_i = 1'b1;
        stop_i  = stop_with_start;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        for (int i = 0; i < n; i++) begin
            pat = {pat[62:0], sig_clk_o};
            if (inject && i == 2) begin
                start_i      = 1'b1;
                cfg_wr_en_i  = 1'b1;
                cfg_period_i = 32'd8;
                cfg_high_i   = 32'd1;
                cfg_pulses_i = 32'd1;
            end
            tick();
            start_i     = 1'b0;
            cfg_wr_en_i = 1'b0;
        end
        chk({tag, "_pattern"}, pat, exp_pat);
        chk({tag, "_done"}, 64'(done_o), 64'd1);
        chk({tag, "_idle"}, 64'({busy_o, sig_clk_o, err_o}), 64'd0);
        chk({tag, "_data"}, done_data_o, exp_data);
        tick();
        chk({tag, "_done_drop"}, 64'(done_o), 64'd0);
        chk({tag, "_data_hold"}, done_data_o, exp_data);
    endtask

    // Start with an invalid latched config and expect a lone err_o pulse
    task automatic err_check(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, "_err"}, 64'({err_o, done_o, busy_o, sig_clk_o}), 64'b1000);
        tick();
        chk({tag, "_after"}, 64'({err_o, done_o, busy_o, sig_clk_o}), 64'b0000);
    endtask

    initial begin
        int k;
        rst_n_i      = 1'b0;
        cfg_wr_en_i  = 1'b0;
        cfg_period_i = '0;
        cfg_high_i   = '0;
        cfg_pulses_i = '0;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 64'({sig_clk_o, busy_o, err_o, done_o}), 64'd0);
        chk("reset_data", done_data_o, 64'd0);
        rst_n_i = 1'b1;
        tick();

        // Basic run: 1100 x3, 12 busy cycles
        write_cfg(4, 2, 3);
        run_and_check("basic", 12, 64'hCCC, exp_dd(12, 3), 1'b0, 1'b0);

        // Shortest legal period: 10 x2
        write_cfg(2, 1, 2);
        run_and_check("min_period", 4, 64'hA, exp_dd(4, 2), 1'b0, 1'b0);

        // start and stop together: stop discarded, both periods emitted
        run_and_check("start_stop", 4, 64'hA, exp_dd(4, 2), 1'b0, 1'b1);

        // stop_i in IDLE does nothing
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("idle_stop", 64'({busy_o, done_o, err_o, sig_clk_o}), 64'd0);

        // Continuous mode stopped in the 3rd cycle of period 7
        write_cfg(5, 1, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 32; i++) tick();
        chk("cont_busy", 64'({busy_o, sig_clk_o}), 64'b10);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        k = 0;
        while (!done_o && k < 20) begin
            tick();
            k++;
        end
        chk("cont_done_latency", 64'(k), 64'd2);
        chk("cont_data", done_data_o, exp_dd(35, 7));

        // Invalid configurations
        write_cfg(1, 1, 0);
        err_check("bad_period");
        write_cfg(5, 0, 0);
        err_check("bad_high0");
        write_cfg(5, 5, 0);
        err_check("bad_high_eq");

        // Reset mid-HIGH aborts with no done, then config must be rewritten
        write_cfg(6, 3, 1);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("pre_rst_high", 64'({busy_o, sig_clk_o}), 64'b11);
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        chk("rst_outputs", 64'({sig_clk_o, busy_o, err_o, done_o}), 64'd0);
        chk("rst_data", done_data_o, 64'd0);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (done_o || busy_o) k++;
            tick();
        end
        chk("rst_no_done", 64'(k), 64'd0);
        err_check("rst_cfg_cleared");
        write_cfg(6, 3, 1);
        run_and_check("post_rst", 6, 64'b111000, exp_dd(6, 1), 1'b0, 1'b0);

        // start and cfg write while busy are ignored
        write_cfg(4, 2, 3);
        run_and_check("busy_ignore", 12, 64'hCCC, exp_dd(12, 3), 1'b1, 1'b0);
        run_and_check("cfg_kept", 12, 64'hCCC, exp_dd(12, 3), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_sig_gen
